// File: rtl/onehot_encoder_reg.sv
`default_nettype none
// ============================================================================
// Module   : onehot_encoder_reg
// Purpose  : Registered one-hot to binary encoder with valid/ready handshake
//            and illegal-code reporting (per-beat flag, sticky, saturating
//            counter). Optional macro ONEHOT_ENC_PRIORITY_EN encodes multi-hot
//            words as the highest set bit instead of flagging them.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_encoder_reg #(
    parameter int N    = 4,
    parameter int W    = $clog2(N),
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_onehot,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_code,
    output logic            out_err,
    output logic            err_sticky,
    output logic [ERRW-1:0] err_cnt,
    input  logic            err_clr
);

    localparam logic [N-1:0]    c_lsb     = N'(1);
    localparam logic [ERRW-1:0] c_cnt_one = ERRW'(1);
    localparam logic [ERRW-1:0] c_cnt_max = '1;

    logic            w_accept;
    logic            w_drain;
    logic            w_zero;
    logic            w_multi;
    logic            w_err;
    logic [W-1:0]    w_hi_idx;
    logic [W-1:0]    w_code;

    logic            r_out_valid;
    logic [W-1:0]    r_out_code;
    logic            r_out_err;
    logic            r_err_sticky;
    logic [ERRW-1:0] r_err_cnt;

    // Highest set bit wins; for a legal word this is simply its index.
    always_comb begin
        w_hi_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (in_onehot[i]) begin
                w_hi_idx = W'(i);
            end
        end
    end

    assign w_zero  = ~|in_onehot;
    assign w_multi = |(in_onehot & (in_onehot - c_lsb));

`ifdef ONEHOT_ENC_PRIORITY_EN
    assign w_err  = w_zero;
    assign w_code = w_hi_idx;
`else
    assign w_err  = w_zero | w_multi;
    assign w_code = w_err ? '0 : w_hi_idx;
`endif

    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_drain  = r_out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_code   <= '0;
            r_out_err    <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_code  <= w_code;
                r_out_err   <= w_err;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end

            // A new error on the same edge as a clear restarts the count at one.
            if (w_accept && w_err) begin
                r_err_sticky <= 1'b1;
                if (err_clr) begin
                    r_err_cnt <= c_cnt_one;
                end else if (r_err_cnt != c_cnt_max) begin
                    r_err_cnt <= r_err_cnt + c_cnt_one;
                end
            end else if (err_clr) begin
                r_err_sticky <= 1'b0;
                r_err_cnt    <= '0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_code   = r_out_code;
    assign out_err    = r_out_err;
    assign err_sticky = r_err_sticky;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire
